uart_tx_arbiter: RTL

Shares the single board UART transmit pin (RsTx) between several game-logic requesters, such as a player-state reporter and a debug/score reporter. It arbitrates round-robin among pending byte requests and serialises the granted byte as 8N1. It sits inside top_vga in the clk (65 MHz pixel clock) domain and drives the oflag output directly.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus and serial-line outputs of the shared UART transmitter
// Ports (signals):
//   req_valid  [N_REQ]    requester i has a byte pending
//   req_data   [8*N_REQ]  byte for requester i in bits [8i+7:8i]
//   req_ready  [N_REQ]    one-hot accept strobe
//   tx                    serial line, idle high
//   busy                  a frame is being shifted out
//   frame_done            one-cycle pulse after the stop bit
//   done_id    [3]        requester of the completed frame
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx;
    logic               busy;
    logic               frame_done;
    logic [2:0]         done_id;
    modport master (
        output req_valid, req_data,
        input  req_ready, tx, busy, frame_done, done_id
    );
    modport slave (
        input  req_valid, req_data,
        output req_ready, tx, busy, frame_done, done_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one 8N1 UART transmit line
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of uart_tx_arbiter_if (requests in, ready/tx/status out)
module uart_tx_arbiter #(
    parameter int CLK_HZ = 65_000_000,
    parameter int BAUD   = 115200,
    parameter int N_REQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int IW  = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int NP  = 2 ** IW;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [IW-1:0]   last_q, last_d, gnt, idx;
    logic [7:0]      shift_q, shift_d;
    logic            fd_q, fd_d;
    logic            gnt_vld, tick, accept;
    logic [NP-1:0]   v_pad;
    logic [8*NP-1:0] d_pad;
    // Round-robin search starting just after the last granted requester
    always_comb begin
        v_pad = NP'(bus.req_valid);
        d_pad = (8 * NP)'(bus.req_data);
        gnt = last_q;
        gnt_vld = 1'b0;
        idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % N_REQ);
            if (!gnt_vld && v_pad[idx]) begin
                gnt_vld = 1'b1;
                gnt = idx;
            end
        end
        accept = state_q == IDLE && gnt_vld && !rst;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            shift_q <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            shift_q <= shift_d;
            fd_q    <= fd_d;
        end
    end
    always_comb begin
        tick = baud_q == CW'(DIV - 1);
        state_d = state_q == IDLE ? (gnt_vld ? START : IDLE) :
                  !tick           ? state_q :
                  state_q == START ? DATA :
                  state_q == STOP  ? IDLE :
                  bit_q == 3'd7    ? STOP : DATA;
        baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
        bit_d   = state_q == DATA ? bit_q + 3'(tick) : '0;
        shift_d = accept ? d_pad[{gnt, 3'b000} +: 8] :
                  (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
        last_d  = accept ? gnt : last_q;
        fd_d    = state_q == STOP && tick;
    end
    always_comb begin
        bus.req_ready  = accept ? N_REQ'(1) << gnt : '0;
        bus.tx         = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
        bus.busy       = state_q != IDLE;
        bus.frame_done = fd_q;
        bus.done_id    = fd_q ? 3'(last_q) : 3'd0;
    end
endmodule
